// File: rtl/cpu_pkg.sv
// Shared constants for the single-cycle CPU: data/PC widths, opcode and funct codes, field positions.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int PC_W   = 5;
  localparam int REG_AW = 3;

  // Instruction field positions
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RS_MSB = 11;
  localparam int RS_LSB = 9;
  localparam int RT_MSB = 8;
  localparam int RT_LSB = 6;
  localparam int RD_MSB = 5;
  localparam int RD_LSB = 3;
  localparam int FN_MSB = 2;
  localparam int FN_LSB = 0;

  localparam logic [3:0] OP_RTYPE = 4'b0001;

  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_SUB = 3'b001;
  localparam logic [2:0] FN_AND = 3'b010;
  localparam logic [2:0] FN_SLT = 3'b011;

endpackage

// File: rtl/data_mem.sv
// Data memory: word-addressed storage with an asynchronous read port.
// Latency: read is combinational; the write port updates on the rising edge.
// Backpressure: none; the current ISA never writes, so the write port is tied off.
module data_mem
  import cpu_pkg::*;
#(
  parameter int DM_DEPTH = 8,
  parameter int DM_AW    = $clog2(DM_DEPTH)
) (
  input  logic              CLK,
  input  logic [DM_AW-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_dat,
  input  logic              wr_en,
  input  logic [DM_AW-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_dat
);

  logic [DATA_W-1:0] DataMemory [DM_DEPTH];

  assign rd_dat = DataMemory[rd_addr];

  // Write port kept for future load/store ops; contents are never reset
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      DataMemory[wr_addr] <= wr_dat;
    end
  end

endmodule

// File: rtl/instr_mem.sv
// Instruction memory: word-addressed storage with an asynchronous read port.
// Latency: read is combinational; the write port updates on the rising edge.
// Backpressure: none; the write port exists for loading and is tied off in the CPU.
module instr_mem
  import cpu_pkg::*;
#(
  parameter int IM_DEPTH = 32
) (
  input  logic              CLK,
  input  logic [PC_W-1:0]   rd_addr,
  output logic [DATA_W-1:0] rd_dat,
  input  logic              wr_en,
  input  logic [PC_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_dat
);

  logic [DATA_W-1:0] InstrMemory [IM_DEPTH];

  assign rd_dat = InstrMemory[rd_addr];

  // Optional load port; contents are never reset
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      InstrMemory[wr_addr] <= wr_dat;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Register file: NREG x 16-bit, two asynchronous read ports and one synchronous write port.
// Latency: reads combinational (old value visible until the edge); write lands on the rising edge.
// Backpressure: none; a write is accepted on every edge where wr_en is high.
module reg_file
  import cpu_pkg::*;
#(
  parameter int NREG = 8
) (
  input  logic              CLK,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_dat,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_dat,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat
);

  // r0 is an ordinary register here, not hardwired to zero
  logic [DATA_W-1:0] Register [NREG];

  assign ra_dat = Register[ra_addr];
  assign rb_dat = Register[rb_addr];

  // Single write port; no reset so contents survive RST
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      Register[wr_addr] <= wr_dat;
    end
  end

endmodule

// File: rtl/cpu_single_cycle.sv
// Single-cycle 16-bit CPU: fetch, R-type execute and register commit all on one rising edge.
// Latency: one instruction per edge while START=1; PC holds when START=0, RST forces PC to 0.
// Backpressure: START is the only stall; macro CPU_SLT_EN builds the signed set-less-than op.
module cpu_single_cycle
  import cpu_pkg::*;
#(
  parameter int IM_DEPTH = 32,
  parameter int NREG     = 8,
  parameter int DM_DEPTH = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic START
);

  localparam int DM_AW = $clog2(DM_DEPTH);

  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_next;
  logic [DATA_W-1:0] instr;

  logic [3:0]        op;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [2:0]        funct;

  logic [DATA_W-1:0] rs_dat;
  logic [DATA_W-1:0] rt_dat;
  logic [DATA_W-1:0] alu_res;
  logic              reg_wr_en;
  logic [DATA_W-1:0] dm_rd_unused;

  assign op    = instr[OP_MSB:OP_LSB];
  assign rs    = instr[RS_MSB:RS_LSB];
  assign rt    = instr[RT_MSB:RT_LSB];
  assign rd    = instr[RD_MSB:RD_LSB];
  assign funct = instr[FN_MSB:FN_LSB];

  instr_mem #(
    .IM_DEPTH (IM_DEPTH)
  ) i_IM (
    .CLK     (CLK),
    .rd_addr (pc),
    .rd_dat  (instr),
    .wr_en   (1'b0),
    .wr_addr ('0),
    .wr_dat  ('0)
  );

  reg_file #(
    .NREG (NREG)
  ) i_Reg (
    .CLK     (CLK),
    .ra_addr (rs),
    .ra_dat  (rs_dat),
    .rb_addr (rt),
    .rb_dat  (rt_dat),
    .wr_en   (reg_wr_en),
    .wr_addr (rd),
    .wr_dat  (alu_res)
  );

  data_mem #(
    .DM_DEPTH (DM_DEPTH)
  ) i_DM (
    .CLK     (CLK),
    .rd_addr (DM_AW'(0)),
    .rd_dat  (dm_rd_unused),
    .wr_en   (1'b0),
    .wr_addr (DM_AW'(0)),
    .wr_dat  ('0)
  );

  // Inline ALU and write enable; anything not decoded falls through as a NOP
  always_comb begin
    alu_res   = '0;
    reg_wr_en = 1'b0;
    if (!RST && START && (op == OP_RTYPE)) begin
      case (funct)
        FN_ADD: begin
          alu_res   = rs_dat + rt_dat;
          reg_wr_en = 1'b1;
        end
        FN_SUB: begin
          alu_res   = rs_dat - rt_dat;
          reg_wr_en = 1'b1;
        end
        FN_AND: begin
          alu_res   = rs_dat & rt_dat;
          reg_wr_en = 1'b1;
        end
`ifdef CPU_SLT_EN
        FN_SLT: begin
          alu_res   = ($signed(rs_dat) < $signed(rt_dat)) ? 16'h0001 : 16'h0000;
          reg_wr_en = 1'b1;
        end
`endif
        default: begin
          alu_res   = '0;
          reg_wr_en = 1'b0;
        end
      endcase
    end
  end

  // Next PC wraps at the top of instruction memory
  always_comb begin
    pc_next = pc + PC_W'(1);
    if (pc == PC_W'(IM_DEPTH - 1)) begin
      pc_next = '0;
    end
  end

  // PC register: reset wins over START
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc <= '0;
    end else if (START) begin
      pc <= pc_next;
    end
  end

endmodule

// File: tb/tb_cpu_single_cycle.sv
// Directed bench for cpu_single_cycle: preloads state hierarchically and checks registers, PC, memory.
// Latency: one edge per instruction; outputs sampled 1 time unit after each rising edge.
// Backpressure: START toggled directly by the stimulus.
module tb_cpu_single_cycle;

  logic CLK;
  logic RST;
  logic START;

  int checks;
  int failures;

  logic [15:0] exp_r [8];

  cpu_single_cycle dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START)
  );

  // Free-running clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < 8; i++) begin
      dut.i_Reg.Register[i]  = 16'(i + 1);
      dut.i_DM.DataMemory[i] = 16'(i + 1);
      exp_r[i]               = 16'(i + 1);
    end
    for (int i = 0; i < 32; i++) begin
      dut.i_IM.InstrMemory[i] = 16'h0000;
    end
  endtask

  task automatic do_reset();
    RST   = 1'b1;
    START = 1'b0;
    tick();
    RST   = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_r%0d", tag, i), dut.i_Reg.Register[i], exp_r[i]);
    end
  endtask

  task automatic check_dm(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_dm%0d", tag, i), dut.i_DM.DataMemory[i], 16'(i + 1));
    end
  endtask

  task automatic check_pc(input string tag, input logic [4:0] expv);
    check(tag, {11'b0, dut.pc}, {11'b0, expv});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST      = 1'b0;
    START    = 1'b0;

    // add r3,r1,r2
    preload();
    dut.i_IM.InstrMemory[0] = 16'h1298;
    do_reset();
    check_pc("reset_pc", 5'd0);
    START = 1'b1;
    tick();
    exp_r[3] = 16'h0005;
    check_regs("add");
    check_pc("add_pc", 5'd1);

    // sub r4,r1,r6 ; slt r7,r4,r0 ; slt r7,r1,r0
    preload();
    dut.i_IM.InstrMemory[0] = 16'h13A1;
    dut.i_IM.InstrMemory[1] = 16'h183B;
    dut.i_IM.InstrMemory[2] = 16'h123B;
    do_reset();
    START = 1'b1;
    tick();
    check("sub_r4", dut.i_Reg.Register[4], 16'hFFFB);
    tick();
`ifdef CPU_SLT_EN
    check("slt_true_r7", dut.i_Reg.Register[7], 16'h0001);
`else
    check("slt_off_a_r7", dut.i_Reg.Register[7], 16'h0008);
`endif
    tick();
`ifdef CPU_SLT_EN
    check("slt_false_r7", dut.i_Reg.Register[7], 16'h0000);
`else
    check("slt_off_b_r7", dut.i_Reg.Register[7], 16'h0008);
`endif
    check_pc("sub_slt_pc", 5'd3);

    // and r5,r6,r2
    preload();
    dut.i_IM.InstrMemory[0] = 16'h1CAA;
    do_reset();
    START = 1'b1;
    tick();
    exp_r[5] = 16'h0003;
    check_regs("and");

    // START=0 hold, then all-zero NOP and a bad-funct R-type NOP
    preload();
    dut.i_IM.InstrMemory[0] = 16'h0000;
    dut.i_IM.InstrMemory[1] = 16'h129F;
    do_reset();
    START = 1'b0;
    tick();
    tick();
    tick();
    check_pc("hold_pc", 5'd0);
    check_regs("hold");
    check_dm("hold");
    START = 1'b1;
    tick();
    check_pc("nop_pc", 5'd1);
    check_regs("nop");
    tick();
    check_pc("badfn_pc", 5'd2);
    check_regs("badfn");

    // Mid-program reset: add r1,r1,r2 (rd==rs reads old value) ; and r5,r6,r2
    preload();
    dut.i_IM.InstrMemory[0] = 16'h1288;
    dut.i_IM.InstrMemory[1] = 16'h1CAA;
    do_reset();
    START = 1'b1;
    tick();
    check("rdrs_r1", dut.i_Reg.Register[1], 16'h0005);
    tick();
    check("mid_r5", dut.i_Reg.Register[5], 16'h0003);
    check_pc("mid_pc", 5'd2);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_pc("mid_rst_pc", 5'd0);
    exp_r[1] = 16'h0005;
    exp_r[5] = 16'h0003;
    check_regs("mid_rst");
    tick();
    exp_r[1] = 16'h0008;
    check_regs("reexec");
    check_pc("reexec_pc", 5'd1);
    check_dm("reexec");

    // PC wrap from 31 back to 0 over NOPs
    preload();
    do_reset();
    START = 1'b1;
    for (int i = 0; i < 31; i++) begin
      tick();
    end
    check_pc("pc_31", 5'd31);
    tick();
    check_pc("pc_wrap", 5'd0);
    check_regs("wrap");
    START = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_single_cycle.md
CPU_SINGLE_CYCLE -- requirements
Module: cpu_single_cycle

Interface
REQ-001 Parameter IM_DEPTH, default 32: instruction memory depth in words.
REQ-002 Parameter NREG, default 8: number of 16-bit general registers.
REQ-003 Parameter DM_DEPTH, default 8: data memory depth in 16-bit words.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 START  input  1  run enable; instructions execute only on edges where START=1.
REQ-007 No data outputs; state is observed hierarchically: i_IM.InstrMemory[IM_DEPTH] (16-bit), i_Reg.Register[NREG] (16-bit), i_DM.DataMemory[DM_DEPTH] (16-bit); these names are mandatory and must stay writable by a bench before the first edge.

Function
REQ-008 Single-cycle: on each rising CLK with RST=0 and START=1, fetch InstrMemory[PC], execute it, commit the result, and set PC <= PC+1.
REQ-009 PC is 5 bits, indexes words, and wraps from IM_DEPTH-1 to 0.
REQ-010 Instruction format: [15:12] opcode, [11:9] rs, [8:6] rt, [5:3] rd, [2:0] funct.
REQ-011 Opcode 4'b0001 is R-type; funct 000 add, 001 sub, 010 and, 011 slt.
REQ-012 add/sub compute Register[rs] +/- Register[rt] modulo 2^16, with no overflow flag.
REQ-013 and is bitwise: Register[rs] & Register[rt].
REQ-014 slt writes 16'h0001 if Register[rs] < Register[rt] (two's-complement signed), else 16'h0000.
REQ-015 Result is written to Register[rd] at the same edge; all registers, including r0, are writable.
REQ-016 Operands are read combinationally before the edge; rd==rs or rd==rt uses the old value.
REQ-017 Any other opcode or funct is a NOP: PC advances, no register or memory write. The all-zero word is therefore a NOP.
REQ-018 START=0 (with RST=0): PC, registers and memories hold.
REQ-019 DataMemory is never written by the supported ISA and holds its preloaded contents indefinitely.

Reset
REQ-020 RST=1 at a rising edge sets PC <= 0 and suppresses execution that cycle; RST has priority over START.
REQ-021 Register file, instruction memory and data memory are not reset; their contents survive RST, including RST asserted mid-program.

Configuration
REQ-022 Macro CPU_SLT_EN: when defined, funct 011 executes slt per REQ-014; when undefined, funct 011 is a NOP per REQ-017 and the comparator is not built.

Structure
REQ-023 Package cpu_pkg holds the opcode and funct constants, field positions, the data width (16) and the PC width (5).
REQ-024 Instances are i_IM (instr_mem, async read), i_Reg (reg_file: 2 async read ports, 1 sync write port) and i_DM (data_mem, no write enable used).
REQ-025 reg_file is the one natural non-trivial sub-module; the ALU stays inline in cpu_single_cycle.

Verification
All scenarios preload Register[i]=DataMemory[i]=i+1 for i=0..7, pulse RST, then set START=1.
REQ-026 add r3,r1,r2 -> Register[3]=16'h0005 after edge 1; other registers unchanged.
REQ-027 sub r4,r1,r6 -> Register[4]=16'hFFFB; then slt r7,r4,r0 -> Register[7]=16'h0001; then slt r7,r1,r0 -> Register[7]=16'h0000.
REQ-028 and r5,r6,r2 -> Register[5]=16'h0003.
REQ-029 Hold START=0 for 3 edges -> PC=0 and all registers and DataMemory[0..7]=1..8 unchanged; an all-zero instruction -> no change except PC+1.
REQ-030 Assert RST after 2 executed instructions -> PC=0, register results retained, instruction 0 re-executes on the next enabled edge; DataMemory stays 1..8 throughout.
REQ-031 Build without CPU_SLT_EN and run slt r7,r1,r0 -> Register[7] stays 16'h0008.
